// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared types and constants for the cache memory interface.
// Burst length on the bus is always encoded as beats minus one.
package mem_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_LAT   = 2'd1,
        ST_RD_BURST = 2'd2,
        ST_WR_STALL = 2'd3
    } resp_state_e;

    localparam logic [1:0] S_IDLE     = ST_IDLE;
    localparam logic [1:0] S_RD_LAT   = ST_RD_LAT;
    localparam logic [1:0] S_RD_BURST = ST_RD_BURST;
    localparam logic [1:0] S_WR_STALL = ST_WR_STALL;

    localparam int BURST_LEN_OFFSET = 1;

    function automatic int word_idx_width(input int mem_words);
        return $clog2(mem_words);
    endfunction

    function automatic int byte_lsb_width(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/burst_mem_responder_if.sv
// rtl/burst_mem_responder_if.sv - cache-to-memory command/data bus.
interface burst_mem_responder_if #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BURST_LEN_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0]      mem_addr;
    logic [BURST_LEN_WIDTH-1:0] mem_burst_len;
    logic                       mem_rd;
    logic                       mem_wr;
    logic [DATA_WIDTH-1:0]      mem_wr_data;
    logic [DATA_WIDTH-1:0]      mem_rd_data;
    logic                       mem_rd_valid;
    logic                       mem_waitrequest;

    modport master (
        output mem_addr, mem_burst_len, mem_rd, mem_wr, mem_wr_data,
        input  mem_rd_data, mem_rd_valid, mem_waitrequest
    );

    modport slave (
        input  mem_addr, mem_burst_len, mem_rd, mem_wr, mem_wr_data,
        output mem_rd_data, mem_rd_valid, mem_waitrequest
    );
endinterface

// File: rtl/sp_ram_1rw.sv
// rtl/sp_ram_1rw.sv - single-port word array with registered, write-first read.
// Only the read register is reset; array contents survive reset.
module sp_ram_1rw #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= we ? wdata : mem_q[addr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/burst_mem_responder.sv
// rtl/burst_mem_responder.sv - backing memory answering read bursts and single-beat writes.
// The RAM read for each beat is issued one cycle ahead so rd_data lands exactly RD_LATENCY after acceptance.
module burst_mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BURST_LEN_WIDTH = 3,
    parameter int MEM_WORDS       = 4096,
    parameter int RD_LATENCY      = 2,
    parameter int WR_STALL_EVERY  = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    burst_mem_responder_if.slave mem,
    output logic                 proto_err
);
    localparam int BYTE_LSB = byte_lsb_width(DATA_WIDTH);
    localparam int IDX_W    = word_idx_width(MEM_WORDS);
    localparam int NB_W     = BURST_LEN_WIDTH + 1;
    localparam int LAT_W    = $clog2(RD_LATENCY) + 1;
    localparam int WC_W     = $clog2(WR_STALL_EVERY + 1) + 1;

    logic [1:0]       state_q, state_d;
    logic [NB_W-1:0]  nbeats_q, nbeats_d;
    logic [NB_W-1:0]  beat_q, beat_d;
    logic [IDX_W-1:0] base_q, base_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [WC_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic             rd_valid_q;
    logic             proto_q, proto_d;

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] req_base;
    logic [NB_W-1:0]  req_nbeats;
    logic             accept, rd_acc, wr_acc;
    logic             issue, ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic             unused_addr;

    assign idx         = mem.mem_addr[BYTE_LSB +: IDX_W];
    assign unused_addr = ^mem.mem_addr;
    assign req_nbeats  = {1'b0, mem.mem_burst_len} + NB_W'(BURST_LEN_OFFSET);
    assign req_base    = idx & ~IDX_W'(mem.mem_burst_len);

    assign mem.mem_waitrequest = (state_q != S_IDLE);
    assign accept = (mem.mem_rd | mem.mem_wr) & ~mem.mem_waitrequest & ~reset;
    assign rd_acc = accept & mem.mem_rd;
    assign wr_acc = accept & mem.mem_wr & ~mem.mem_rd;

    always_comb begin
        state_d  = state_q;
        nbeats_d = nbeats_q;
        beat_d   = beat_q;
        base_d   = base_q;
        lat_d    = lat_q;
        wr_cnt_d = wr_cnt_q;
        proto_d  = proto_q;
        issue    = 1'b0;
        ram_we   = 1'b0;
        ram_addr = idx;
        case (state_q)
            S_IDLE: begin
                if (rd_acc) begin
                    nbeats_d = req_nbeats;
                    base_d   = req_base;
                    lat_d    = '0;
                    proto_d  = proto_q | mem.mem_wr;
                    if (RD_LATENCY > 1) begin
                        beat_d  = '0;
                        state_d = S_RD_LAT;
                    end else begin
                        issue    = 1'b1;
                        ram_addr = req_base;
                        beat_d   = NB_W'(1);
                        state_d  = S_RD_BURST;
                    end
                end else if (wr_acc) begin
                    ram_we = 1'b1;
                    if (WR_STALL_EVERY != 0) begin
                        if (wr_cnt_q == WC_W'(WR_STALL_EVERY - 1)) begin
                            wr_cnt_d = '0;
                            state_d  = S_WR_STALL;
                        end else begin
                            wr_cnt_d = wr_cnt_q + 1'b1;
                        end
                    end
                end
            end
            S_RD_LAT: begin
                if (lat_q == LAT_W'(RD_LATENCY - 2)) begin
                    issue    = 1'b1;
                    ram_addr = base_q + IDX_W'(beat_q);
                    beat_d   = beat_q + 1'b1;
                    state_d  = S_RD_BURST;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_RD_BURST: begin
                // beat_q counts issued beats; the last one is on the bus once all are issued.
                if (beat_q != nbeats_q) begin
                    issue    = 1'b1;
                    ram_addr = base_q + IDX_W'(beat_q);
                    beat_d   = beat_q + 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_STALL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            nbeats_q   <= '0;
            beat_q     <= '0;
            base_q     <= '0;
            lat_q      <= '0;
            wr_cnt_q   <= '0;
            rd_valid_q <= 1'b0;
            proto_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            nbeats_q   <= nbeats_d;
            beat_q     <= beat_d;
            base_q     <= base_d;
            lat_q      <= lat_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_valid_q <= issue;
            proto_q    <= proto_d;
        end
    end

    sp_ram_1rw #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(MEM_WORDS),
        .AW   (IDX_W)
    ) u_ram (
        .clock(clock),
        .reset(reset),
        .we   (ram_we),
        .re   (issue),
        .addr (ram_addr),
        .wdata(mem.mem_wr_data),
        .rdata(mem.mem_rd_data)
    );

    assign mem.mem_rd_valid = rd_valid_q;
    assign proto_err        = proto_q;
endmodule

// File: tb/tb_burst_mem_responder.sv
// tb/tb_burst_mem_responder.sv - randomized bench against a transaction-level memory model.
module tb_burst_mem_responder;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BLW   = 3;
    localparam int WORDS = 4096;
    localparam int LAT   = 2;
    localparam int STALL = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic proto_err;

    always #5 clock = ~clock;

    burst_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN_WIDTH(BLW)) mem_bus ();

    burst_mem_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN_WIDTH(BLW),
        .MEM_WORDS(WORDS), .RD_LATENCY(LAT), .WR_STALL_EVERY(STALL)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .mem      (mem_bus),
        .proto_err(proto_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        int          at;
        logic [31:0] data;
    } beat_t;

    logic [31:0] ref_mem [WORDS];
    beat_t       exp_q[$];
    int          cyc        = 0;
    int          busy_until = -1;
    int          wcnt       = 0;
    bit          proto_m    = 1'b0;
    bit          acc_flag   = 1'b0;
    int          acc_cyc    = 0;
    bit          mon_on     = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Model: each accepted read schedules its beats RD_LATENCY cycles out; the bus is busy until the last one.
    always @(negedge clock) begin : monitor
        bit exp_wait;
        int nb, idx, base;
        if (mon_on) begin
            exp_wait = (cyc <= busy_until);
            check_eq("waitreq", mem_bus.mem_waitrequest, exp_wait);
            check_eq("proto_err", proto_err, proto_m);
            if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                check_eq("rd_valid", mem_bus.mem_rd_valid, 1);
                check_eq("rd_data", mem_bus.mem_rd_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end else begin
                check_eq("rd_valid_idle", mem_bus.mem_rd_valid, 0);
            end
            acc_flag = 1'b0;
            if (reset) begin
                exp_q.delete();
                busy_until = cyc;
                wcnt       = 0;
                proto_m    = 1'b0;
            end else if ((mem_bus.mem_rd || mem_bus.mem_wr) && !exp_wait) begin
                acc_flag = 1'b1;
                acc_cyc  = cyc;
                idx = int'((mem_bus.mem_addr >> 2) % WORDS);
                if (mem_bus.mem_rd) begin
                    nb   = int'(mem_bus.mem_burst_len) + 1;
                    base = idx - (idx % nb);
                    for (int i = 0; i < nb; i++)
                        exp_q.push_back('{at: cyc + LAT + i, data: ref_mem[base + i]});
                    busy_until = cyc + LAT + nb - 1;
                    if (mem_bus.mem_wr) proto_m = 1'b1;
                end else begin
                    ref_mem[idx] = mem_bus.mem_wr_data;
                    wcnt++;
                    if (wcnt == STALL) begin
                        wcnt       = 0;
                        busy_until = cyc + 1;
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic xfer(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [2:0] len, input logic [31:0] data, output int at);
        int n;
        mem_bus.mem_rd        = rd;
        mem_bus.mem_wr        = wr;
        mem_bus.mem_addr      = addr;
        mem_bus.mem_burst_len = len;
        mem_bus.mem_wr_data   = data;
        n = 0;
        do begin
            @(posedge clock);
            n++;
        end while (!acc_flag && n < 64);
        if (!acc_flag) check_eq("accept_timeout", n, 0);
        at = acc_cyc;
        #1;
        mem_bus.mem_rd = 1'b0;
        mem_bus.mem_wr = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || cyc <= busy_until) && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 200) check_eq("drain_timeout", n, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    int          acc;
    int          acc_at[5];
    int          stall_exp[5] = '{0, 1, 3, 4, 6};
    int          op, idx_r;
    logic [31:0] a_r;
    logic [2:0]  len_r;

    initial begin
        mem_bus.mem_rd        = 1'b0;
        mem_bus.mem_wr        = 1'b0;
        mem_bus.mem_addr      = '0;
        mem_bus.mem_burst_len = '0;
        mem_bus.mem_wr_data   = '0;
        repeat (3) @(posedge clock);
        #1;
        reset  = 1'b0;
        mon_on = 1'b1;
        @(negedge clock);
        check_eq("rst_rd_data", mem_bus.mem_rd_data, 0);
        check_eq("rst_rd_valid", mem_bus.mem_rd_valid, 0);
        idle(5);

        for (int i = 0; i < 256; i++)
            xfer(1'b0, 1'b1, i * 4, 3'd0, (i * 32'h0101_0101) ^ 32'h5A5A_0000, acc);
        drain();

        for (int i = 0; i < 4; i++)
            xfer(1'b0, 1'b1, 32'h100 + i * 4, 3'd0, 32'hA0 + i, acc);
        xfer(1'b1, 1'b0, 32'h108, 3'd3, 32'h0, acc);
        drain();

        do_reset();
        for (int i = 0; i < 5; i++) begin
            xfer(1'b0, 1'b1, 32'h180 + i * 4, 3'd0, 32'hC0 + i, acc);
            acc_at[i] = acc;
        end
        for (int i = 0; i < 5; i++)
            check_eq("stall_accept_cycle", acc_at[i] - acc_at[0], stall_exp[i]);
        drain();
        for (int i = 0; i < 5; i++)
            xfer(1'b1, 1'b0, 32'h180 + i * 4, 3'd0, 32'h0, acc);
        drain();

        xfer(1'b0, 1'b1, 32'h200, 3'd0, 32'hDEAD_BEEF, acc);
        xfer(1'b1, 1'b0, 32'h200, 3'd0, 32'h0, acc);
        drain();

        xfer(1'b0, 1'b1, 32'h300, 3'd0, 32'h11, acc);
        drain();
        xfer(1'b1, 1'b1, 32'h300, 3'd0, 32'h22, acc);
        drain();
        idle(3);
        check_eq("proto_sticky", proto_err, 1);
        xfer(1'b1, 1'b0, 32'h300, 3'd0, 32'h0, acc);
        drain();

        xfer(1'b1, 1'b0, 32'h100, 3'd3, 32'h0, acc);
        idle(2);
        do_reset();
        @(negedge clock);
        check_eq("abort_rd_valid", mem_bus.mem_rd_valid, 0);
        check_eq("abort_waitreq", mem_bus.mem_waitrequest, 0);
        check_eq("abort_proto", proto_err, 0);
        idle(1);
        xfer(1'b1, 1'b0, 32'h100, 3'd3, 32'h0, acc);
        drain();

        for (int t = 0; t < 300; t++) begin
            op    = $urandom_range(0, 9);
            idx_r = $urandom_range(0, 255);
            a_r   = ($urandom() & ~32'h0000_3FFC) | (idx_r << 2);
            len_r = 3'((1 << $urandom_range(0, 3)) - 1);
            if (op < 4)
                xfer(1'b0, 1'b1, a_r, len_r, $urandom(), acc);
            else if (op < 9)
                xfer(1'b1, 1'b0, a_r, len_r, $urandom(), acc);
            else
                xfer(1'b1, 1'b1, a_r, len_r, $urandom(), acc);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
